// File: rtl/alu_acc_pipe_if.sv
// alu_acc_pipe_if -- operand/result handshake bundle for alu_acc_pipe.
//   in_valid/in_ready : operand beat handshake (a, b, op, acc_clr ride with it;
//                       acc_clr is also honoured on its own, without in_valid)
//   out_valid/out_ready: result beat handshake (c, ovf)
//   ovf_sticky        : OR of all ovf since reset or acc_clr
// master = the side that issues operands and consumes results; slave = the ALU.
interface alu_acc_pipe_if #(
    parameter int W_IN  = 36,
    parameter int W_OUT = 55
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W_IN-1:0]  a;
    logic signed [W_IN-1:0]  b;
    logic [1:0]              op;
    logic                    acc_clr;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [W_OUT-1:0] c;
    logic                    ovf;
    logic                    ovf_sticky;

    modport master (
        output in_valid, a, b, op, acc_clr, out_ready,
        input  in_ready, out_valid, c, ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, a, b, op, acc_clr, out_ready,
        output in_ready, out_valid, c, ovf, ovf_sticky
    );
endinterface

// File: rtl/alu_acc_pipe.sv
// alu_acc_pipe -- pipelined signed add/sub ALU with a running accumulator.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : alu_acc_pipe_if.slave
//         op 00 a+b, 01 a-b (exact, no accumulator effect)
//         op 10 acc+=a, 11 acc-=a (result is the new accumulator value)
// Stage 1 computes; stages 2..PIPE only delay. A single global stall
// (output valid but not taken) freezes every stage, so in_ready never
// depends on in_valid.
module alu_acc_pipe #(
    parameter int W_IN  = 36,
    parameter int W_OUT = 55,
    parameter int PIPE  = 2,
    parameter int SAT   = 0
) (
    input  logic          clk,
    input  logic          rst,
    alu_acc_pipe_if.slave bus
);
    localparam int WX = W_OUT + 1;

    logic                          stall;
    logic                          accept;
    logic [PIPE:1]                 vld_pipe;
    logic [PIPE:1][W_OUT-1:0]      c_pipe;
    logic [PIPE:1]                 ovf_pipe;
    logic signed [W_OUT-1:0]       acc;
    logic                          ovf_sticky;

    logic signed [W_OUT-1:0]       a_w, b_w, acc_base, acc_next, res;
    logic signed [WX-1:0]          acc_x, a_x, sum_x;
    logic                          acc_ovf, res_ovf;

    assign stall         = vld_pipe[PIPE] && !bus.out_ready;
    assign accept        = bus.in_valid && !stall;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = vld_pipe[PIPE];
    assign bus.c         = c_pipe[PIPE];
    assign bus.ovf       = ovf_pipe[PIPE];
    assign bus.ovf_sticky = ovf_sticky;

    // A clear in the same cycle as an accumulate op acts first, so the op
    // starts from zero.
    assign acc_base = bus.acc_clr ? '0 : acc;
    assign a_w      = {{(W_OUT-W_IN){bus.a[W_IN-1]}}, bus.a};
    assign b_w      = {{(W_OUT-W_IN){bus.b[W_IN-1]}}, bus.b};

    always_comb begin
        acc_x    = {acc_base[W_OUT-1], acc_base};
        a_x      = {a_w[W_OUT-1], a_w};
        sum_x    = bus.op[0] ? (acc_x - a_x) : (acc_x + a_x);
        // One guard bit: overflow when it disagrees with the result sign.
        acc_ovf  = sum_x[WX-1] != sum_x[WX-2];
        acc_next = sum_x[W_OUT-1:0];
        if (SAT != 0 && acc_ovf)
            acc_next = sum_x[WX-1] ? {1'b1, {(W_OUT-1){1'b0}}}
                                   : {1'b0, {(W_OUT-1){1'b1}}};
        res     = '0;
        res_ovf = 1'b0;
        if (bus.op[1]) begin
            res     = acc_next;
            res_ovf = acc_ovf;
        end else begin
            // W_OUT > W_IN, so plain add/sub of the extended operands is exact.
            res = bus.op[0] ? (a_w - b_w) : (a_w + b_w);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe   <= '0;
            c_pipe     <= '0;
            ovf_pipe   <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (!stall) begin
                for (int k = PIPE; k >= 2; k--) begin
                    vld_pipe[k] <= vld_pipe[k-1];
                    c_pipe[k]   <= c_pipe[k-1];
                    ovf_pipe[k] <= ovf_pipe[k-1];
                end
                vld_pipe[1] <= accept;
                if (accept) begin
                    c_pipe[1]   <= res;
                    ovf_pipe[1] <= res_ovf;
                end
            end
            if (accept && bus.op[1])
                acc <= acc_next;
            else if (bus.acc_clr)
                acc <= '0;
            if (bus.acc_clr)
                ovf_sticky <= accept && res_ovf;
            else if (accept && res_ovf)
                ovf_sticky <= 1'b1;
        end
    end
endmodule

// File: doc/alu_acc_pipe.md
ALU_ACC_PIPE -- requirements
Module: alu_acc_pipe

Interface
REQ-001 SHALL have parameter W_IN, default 36, signed operand width (2..64).
REQ-002 SHALL have parameter W_OUT, default 55, signed result/accumulator width; W_OUT >= W_IN+1 is a legal-configuration requirement.
REQ-003 SHALL have parameter PIPE, default 2, input-accept to out_valid latency in cycles (1..4).
REQ-004 SHALL have parameter SAT, default 0; 1 = accumulator saturates, 0 = accumulator wraps.
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  operand beat present.
REQ-008 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-009 SHALL have port a  input  W_IN  signed operand A.
REQ-010 SHALL have port b  input  W_IN  signed operand B.
REQ-011 SHALL have port op  input  2  00 a+b, 01 a-b, 10 acc+=a, 11 acc-=a.
REQ-012 SHALL have port acc_clr  input  1  synchronous accumulator and sticky-flag clear.
REQ-013 SHALL have port out_valid  output  1  result beat present.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port c  output  W_OUT  signed result.
REQ-016 SHALL have port ovf  output  1  per-beat overflow/saturation flag, aligned with c.
REQ-017 SHALL have port ovf_sticky  output  1  OR of all ovf since reset/acc_clr.

Function
REQ-018 SHALL accept a beat when in_valid && in_ready; op, a, b are sampled only then.
REQ-019 SHALL hold a PIPE-stage valid/data pipeline; stage 1 computes, stages 2..PIPE are register-only delay.
REQ-020 SHALL assert stall = out_valid && !out_ready; stall freezes all stages, c, ovf, out_valid.
REQ-021 SHALL drive in_ready = !stall (combinational); no combinational path from in_valid to in_ready.
REQ-022 SHALL present the result of the beat accepted at edge N on c with out_valid=1 after edge N+PIPE-1 when never stalled (PIPE=1: visible after the accepting edge).
REQ-023 SHALL hold c and ovf stable while out_valid && !out_ready.
REQ-024 SHALL sign-extend a and b to W_OUT for ops 00/01; result exact, ovf=0, acc unchanged.
REQ-025 SHALL for ops 10/11 compute acc_next = acc ± sext(a) with W_OUT+1-bit intermediate, update acc on accept, and output acc_next as c.
REQ-026 SHALL on accumulator overflow set ovf=1; SAT=1 clamps to 2^(W_OUT-1)-1 or -2^(W_OUT-1); SAT=0 keeps low W_OUT bits.
REQ-027 SHALL act on acc_clr every cycle it is high, regardless of stall or in_valid: acc<=0, ovf_sticky<=0.
REQ-028 SHALL, when acc_clr coincides with an accepted op 10/11, use acc=0 as operand (clear first), and set ovf_sticky from that beat's ovf.
REQ-029 SHALL order accumulator updates strictly by acceptance; back-to-back accepted acc ops use the previous beat's acc_next (no hazard bubbles).
REQ-030 SHALL set ovf_sticky when a beat with ovf=1 is accepted at stage 1.

Reset
REQ-031 SHALL on rst: all stage valids 0, out_valid=0, c=0, ovf=0, ovf_sticky=0, acc=0; in_ready=1 after reset.
REQ-032 SHALL discard in-flight beats on rst mid-operation; no result for them is ever produced.

Verification
REQ-033 W_IN=36,PIPE=2: a=34359738367,b=-34359738368,op=01 -> 2 cycles later c=68719476735, ovf=0.
REQ-034 ops 10 with a=5,-3,10 back-to-back, out_ready=1 -> c sequence 5,2,12, one per cycle, no bubbles.
REQ-035 out_ready=0 for 3 cycles with 4 beats offered -> in_ready drops once pipe full, no beat lost/duplicated, order preserved on release.
REQ-036 W_IN=8,W_OUT=10,SAT=1: op=10 a=127 x5 -> c=127,254,381,508,511; ovf=1 on 5th only; ovf_sticky=1; SAT=0 5th c=-389.
REQ-037 acc_clr with accepted op=10 a=7 while acc=100 -> c=7, ovf_sticky=0.
REQ-038 rst asserted with 2 beats in flight -> out_valid=0 immediately, c=0, acc=0; next op=10 a=1 -> c=1.
